// File: rtl/pipe_pkg.sv
// Shared types for the pipeline backbone: default geometry, stage record and
// the per-stage register action.
package pipe_pkg;

    localparam int unsigned DEF_NUM_STAGES = 5;
    localparam int unsigned DEF_DATA_W     = 96;
    localparam int unsigned DEF_TAG_W      = 5;
    localparam int unsigned DEF_NUM_Q      = 2;

    typedef logic [$clog2(DEF_NUM_STAGES)-1:0] stage_idx_t;
    typedef logic [DEF_TAG_W-1:0]              tag_t;

    typedef struct packed {
        logic                  valid;
        logic                  wen;
        tag_t                  tag;
        logic [DEF_DATA_W-1:0] data;
    } stage_t;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_HOLD,
        ST_FLUSH
    } stage_act_e;

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register: keeps its contents on hold, loads from its
// predecessor otherwise, and drops validity on flush.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned TAG_W  = DEF_TAG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic              ld_valid_i,
    input  logic              ld_wen_i,
    input  logic [TAG_W-1:0]  ld_tag_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic              valid_o,
    output logic              wen_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [DATA_W-1:0] data_o
);

    stage_act_e        act;
    logic              valid_q, valid_d;
    logic              wen_q, wen_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Flush wins over hold so a stalled stage can still be squashed.
    always_comb begin
        act = ST_LOAD;
        if (flush_i) begin
            act = ST_FLUSH;
        end else if (hold_i) begin
            act = ST_HOLD;
        end
    end

    always_comb begin
        valid_d = valid_q;
        wen_d   = wen_q;
        tag_d   = tag_q;
        data_d  = data_q;
        unique case (act)
            ST_LOAD: begin
                valid_d = ld_valid_i;
                wen_d   = ld_valid_i & ld_wen_i;
                tag_d   = ld_tag_i;
                data_d  = ld_data_i;
            end
            ST_FLUSH: begin
                valid_d = 1'b0;
                wen_d   = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            wen_q   <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            wen_q   <= wen_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign wen_o   = wen_q;
    assign tag_o   = tag_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_ctrl.sv
// N-stage elastic pipeline backbone with per-stage stall, younger-stage flush,
// bubble insertion, destination-tag tracking and RAW hazard queries.
module pipe_stage_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned NUM_STAGES = DEF_NUM_STAGES,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned TAG_W      = DEF_TAG_W,
    parameter int unsigned NUM_Q      = DEF_NUM_Q
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [DATA_W-1:0]                    in_data,
    input  logic [TAG_W-1:0]                     in_tag,
    input  logic                                 in_wen,
    input  logic [NUM_STAGES-1:0]                stall_req,
    input  logic                                 flush_req,
    input  logic [$clog2(NUM_STAGES)-1:0]        flush_stage,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [DATA_W-1:0]                    out_data,
    output logic [NUM_STAGES-1:0]                stage_valid,
    output logic [NUM_STAGES*DATA_W-1:0]         stage_data,
    input  logic [NUM_Q*TAG_W-1:0]               q_tag,
    output logic [NUM_Q-1:0]                     q_hit,
    output logic [NUM_Q*$clog2(NUM_STAGES)-1:0]  q_stage,
    output logic [31:0]                          retire_cnt
);

    localparam int unsigned      SW   = $clog2(NUM_STAGES);
    localparam logic [SW-1:0]    LAST = SW'(NUM_STAGES - 1);

    logic [NUM_STAGES-1:0] valid;
    logic [NUM_STAGES-1:0] wen;
    logic [NUM_STAGES-1:0] hold;
    logic [TAG_W-1:0]      tag  [NUM_STAGES];
    logic [DATA_W-1:0]     data [NUM_STAGES];
    logic [SW-1:0]         flush_lim;
    logic                  out_xfer;
    logic [31:0]           retire_q, retire_d;

    // Hold propagates from the oldest stage backwards; empty stages break the chain.
    always_comb begin
        hold = '0;
        hold[NUM_STAGES-1] = valid[NUM_STAGES-1] & (stall_req[NUM_STAGES-1] | ~out_ready);
        for (int unsigned s = NUM_STAGES - 1; s > 0; s--) begin
            hold[s-1] = valid[s-1] & (stall_req[s-1] | hold[s]);
        end
    end

    assign flush_lim = (flush_stage > LAST) ? LAST : flush_stage;

    generate
        for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
            logic              ld_valid;
            logic              ld_wen;
            logic [TAG_W-1:0]  ld_tag;
            logic [DATA_W-1:0] ld_data;
            logic              flush_s;

            if (s == 0) begin : g_head
                assign ld_valid = in_valid;
                assign ld_wen   = in_wen;
                assign ld_tag   = in_tag;
                assign ld_data  = in_data;
            end else begin : g_body
                assign ld_valid = valid[s-1] & ~hold[s-1];
                assign ld_wen   = wen[s-1];
                assign ld_tag   = tag[s-1];
                assign ld_data  = data[s-1];
            end

            assign flush_s = flush_req & (SW'(s) <= flush_lim);

            pipe_stage_reg #(
                .DATA_W (DATA_W),
                .TAG_W  (TAG_W)
            ) u_stage (
                .clk        (clk),
                .rst        (rst),
                .hold_i     (hold[s]),
                .flush_i    (flush_s),
                .ld_valid_i (ld_valid),
                .ld_wen_i   (ld_wen),
                .ld_tag_i   (ld_tag),
                .ld_data_i  (ld_data),
                .valid_o    (valid[s]),
                .wen_o      (wen[s]),
                .tag_o      (tag[s]),
                .data_o     (data[s])
            );

            assign stage_data[s*DATA_W +: DATA_W] = data[s];
        end
    endgenerate

    // Stage 0 is the querying instruction itself, so the scan starts at stage 1;
    // scanning oldest-first lets the youngest match overwrite the result.
    generate
        for (genvar i = 0; i < NUM_Q; i++) begin : g_query
            logic [TAG_W-1:0] qt;
            logic             hit;
            logic [SW-1:0]    stg;

            assign qt = q_tag[i*TAG_W +: TAG_W];

            always_comb begin
                hit = 1'b0;
                stg = '0;
                for (int unsigned s = NUM_STAGES - 1; s >= 1; s--) begin
                    if (valid[s] && wen[s] && (tag[s] == qt) && (qt != '0)) begin
                        hit = 1'b1;
                        stg = SW'(s);
                    end
                end
            end

            assign q_hit[i]            = hit;
            assign q_stage[i*SW +: SW] = stg;
        end
    endgenerate

    assign out_xfer = valid[NUM_STAGES-1] & ~hold[NUM_STAGES-1];
    assign retire_d = retire_q + 32'(out_xfer);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_q <= '0;
        end else begin
            retire_q <= retire_d;
        end
    end

    assign in_ready    = ~hold[0];
    assign out_valid   = valid[NUM_STAGES-1];
    assign out_data    = data[NUM_STAGES-1];
    assign stage_valid = valid;
    assign retire_cnt  = retire_q;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Self-checking bench for pipe_stage_ctrl: directed scenarios plus a random
// run compared against an entry-level model of the pipeline.
module tb_pipe_stage_ctrl;

    localparam int N  = 5;
    localparam int DW = 96;
    localparam int TW = 5;
    localparam int NQ = 2;
    localparam int SW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready, in_wen;
    logic [DW-1:0]     in_data;
    logic [TW-1:0]     in_tag;
    logic [N-1:0]      stall_req;
    logic              flush_req;
    logic [SW-1:0]     flush_stage;
    logic              out_valid, out_ready;
    logic [DW-1:0]     out_data;
    logic [N-1:0]      stage_valid;
    logic [N*DW-1:0]   stage_data;
    logic [NQ*TW-1:0]  q_tag;
    logic [NQ-1:0]     q_hit;
    logic [NQ*SW-1:0]  q_stage;
    logic [31:0]       retire_cnt;

    always #5 clk = ~clk;

    pipe_stage_ctrl #(
        .NUM_STAGES (N),
        .DATA_W     (DW),
        .TAG_W      (TW),
        .NUM_Q      (NQ)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_tag      (in_tag),
        .in_wen      (in_wen),
        .stall_req   (stall_req),
        .flush_req   (flush_req),
        .flush_stage (flush_stage),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .stage_valid (stage_valid),
        .stage_data  (stage_data),
        .q_tag       (q_tag),
        .q_hit       (q_hit),
        .q_stage     (q_stage),
        .retire_cnt  (retire_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Model: one entry slot per stage, entries slide toward the output.
    logic          mv [N];
    logic          mw [N];
    logic [TW-1:0] mt [N];
    logic [DW-1:0] md [N];
    logic [31:0]   mcnt;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got_q [$];

    function automatic logic [N-1:0] m_stuck();
        logic [N-1:0] b;
        logic         ahead_stuck;
        ahead_stuck = ~out_ready;
        for (int s = N - 1; s >= 0; s--) begin
            b[s] = mv[s] && (stall_req[s] || ahead_stuck);
            ahead_stuck = b[s];
        end
        return b;
    endfunction

    function automatic logic [N-1:0] m_valid_vec();
        logic [N-1:0] v;
        for (int s = 0; s < N; s++) v[s] = mv[s];
        return v;
    endfunction

    task automatic m_query(input logic [TW-1:0] t, output logic h, output logic [SW-1:0] st);
        h  = 1'b0;
        st = '0;
        if (t != 0) begin
            for (int s = 1; s < N; s++) begin
                if (!h && mv[s] && mw[s] && mt[s] == t) begin
                    h  = 1'b1;
                    st = SW'(s);
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < N; s++) begin
            mv[s] = 1'b0; mw[s] = 1'b0; mt[s] = '0; md[s] = '0;
        end
        mcnt = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic model_advance();
        logic [N-1:0] b;
        int           lim;
        b = m_stuck();
        if (mv[N-1] && !b[N-1]) begin
            exp_q.push_back(md[N-1]);
            mcnt = mcnt + 1;
        end
        for (int s = N - 1; s >= 1; s--) begin
            if (!b[s]) begin
                mv[s] = mv[s-1] && !b[s-1];
                mw[s] = mv[s] && mw[s-1];
                mt[s] = mt[s-1];
                md[s] = md[s-1];
            end
        end
        if (!b[0]) begin
            mv[0] = in_valid;
            mw[0] = in_valid && in_wen;
            mt[0] = in_tag;
            md[0] = in_data;
        end
        if (flush_req) begin
            lim = (int'(flush_stage) > N - 1) ? N - 1 : int'(flush_stage);
            for (int s = 0; s <= lim; s++) begin
                mv[s] = 1'b0;
                mw[s] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        #1;
        if (out_valid && out_ready && !stall_req[N-1]) got_q.push_back(out_data);
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        in_valid = 0; in_data = '0; in_tag = '0; in_wen = 0;
        stall_req = '0; flush_req = 0; flush_stage = '0;
        out_ready = 1; q_tag = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        q_tag = {5'd7, 5'd7};
        rst = 1;
        model_reset();
        #3;
        checks++; if (stage_valid !== 5'b0) $display("FAIL reset_valid got=%b exp=%b", stage_valid, 5'b0);
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        checks++; if (retire_cnt !== 32'd0) $display("FAIL reset_cnt got=%0d exp=0", retire_cnt);
        checks++; if (q_hit !== 2'b00) $display("FAIL reset_q_hit got=%b exp=00", q_hit);
        @(posedge clk);
        #1;
        rst = 0;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        if (stage_valid !== 5'b0 || out_valid !== 1'b0 || retire_cnt !== 32'd0 || q_hit !== 2'b00 || in_ready !== 1'b1)
            errors++;
    endtask

    task automatic test_stream();
        int first = -1, last = -1, nvalid = 0;
        logic ok;
        do_reset();
        for (int t = 0; t < 14; t++) begin
            in_valid = (t < 8);
            in_data  = DW'(t + 1);
            tick();
            if (out_valid) begin
                if (first < 0) first = t;
                last = t;
                nvalid++;
            end
        end
        in_valid = 0;
        checks++; if (first !== 4) begin errors++; $display("FAIL stream_latency got=%0d exp=4", first); end
        checks++; if (nvalid !== 8 || last - first !== 7) begin errors++; $display("FAIL stream_rate got=%0d/%0d exp=8/7", nvalid, last - first); end
        checks++; if (retire_cnt !== 32'd8) begin errors++; $display("FAIL stream_cnt got=%0d exp=8", retire_cnt); end
        ok = (got_q.size() == 8);
        for (int i = 0; i < got_q.size() && i < 8; i++) if (got_q[i] !== DW'(i + 1)) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL stream_order got_n=%0d exp_n=8", got_q.size()); end
    endtask

    task automatic test_stall();
        int seq = 1;
        logic [N-1:0] b;
        logic ok;
        do_reset();
        for (int t = 0; t < 15; t++) begin
            stall_req = (t >= 6 && t < 9) ? 5'b00100 : 5'b00000;
            in_valid  = 1;
            in_data   = DW'(seq);
            #1;
            b = m_stuck();
            if (stall_req[2]) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready t=%0d got=%b exp=0", t, in_ready); end
            end
            tick();
            if (!b[0]) seq++;
            if (t == 8) begin
                checks++; if (stage_valid !== 5'b00111) begin errors++; $display("FAIL stall_bubbles got=%b exp=00111", stage_valid); end
            end
        end
        in_valid  = 0;
        stall_req = '0;
        for (int t = 0; t < 8; t++) tick();
        ok = (got_q.size() == seq - 1);
        for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== DW'(i + 1)) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL stall_no_loss got_n=%0d exp_n=%0d", got_q.size(), seq - 1); end
    endtask

    task automatic test_backpressure();
        int seq = 1;
        logic [N-1:0] b;
        do_reset();
        out_ready = 0;
        for (int t = 0; t < 10; t++) begin
            in_valid = 1;
            in_data  = DW'(seq);
            #1;
            b = m_stuck();
            if (t >= 5) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready t=%0d got=%b exp=0", t, in_ready); end
            end
            tick();
            if (!b[0]) seq++;
        end
        checks++; if (stage_valid !== 5'b11111) begin errors++; $display("FAIL bp_full got=%b exp=11111", stage_valid); end
        checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL bp_cnt got=%0d exp=0", retire_cnt); end
        for (int s = 0; s < N; s++) begin
            checks++;
            if (stage_data[s*DW +: DW] !== DW'(N - s)) begin
                errors++; $display("FAIL bp_data s=%0d got=%h exp=%h", s, stage_data[s*DW +: DW], DW'(N - s));
            end
        end
    endtask

    task automatic test_flush();
        logic ok;
        got_q.delete();
        exp_q.delete();
        out_ready   = 0;
        flush_req   = 1;
        flush_stage = 3'd2;
        in_valid    = 1;
        in_data     = DW'(32'hAA);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        tick();
        flush_req = 0;
        in_valid  = 0;
        checks++; if (stage_valid !== 5'b11000) begin errors++; $display("FAIL flush_valid got=%b exp=11000", stage_valid); end
        out_ready = 1;
        for (int t = 0; t < 6; t++) tick();
        ok = (got_q.size() == 2) && (got_q[0] === DW'(1)) && (got_q[1] === DW'(2));
        checks++; if (!ok) begin errors++; $display("FAIL flush_retire got_n=%0d exp_n=2", got_q.size()); end
        checks++; if (retire_cnt !== 32'd2) begin errors++; $display("FAIL flush_cnt got=%0d exp=2", retire_cnt); end
    endtask

    task automatic fill_tags(input logic [TW-1:0] t0, t1, t2, t3, t4, input logic [4:0] w);
        logic [TW-1:0] tags [5];
        tags = '{t0, t1, t2, t3, t4};
        do_reset();
        out_ready = 0;
        for (int e = 0; e < 5; e++) begin
            in_valid = 1;
            in_data  = DW'(e + 16);
            in_tag   = tags[e];
            in_wen   = w[e];
            tick();
        end
        in_valid = 0;
        in_wen   = 0;
    endtask

    task automatic test_hazard();
        // entry e lands in stage 4-e
        fill_tags(5'd7, 5'd3, 5'd7, 5'd3, 5'd7, 5'b11111);
        q_tag = {5'd0, 5'd7};
        #1;
        checks++; if (q_hit[0] !== 1'b1 || q_stage[2:0] !== 3'd2) begin errors++; $display("FAIL haz_youngest got=%b/%0d exp=1/2", q_hit[0], q_stage[2:0]); end
        checks++; if (q_hit[1] !== 1'b0 || q_stage[5:3] !== 3'd0) begin errors++; $display("FAIL haz_tag0 got=%b/%0d exp=0/0", q_hit[1], q_stage[5:3]); end
        q_tag = {5'd9, 5'd3};
        #1;
        checks++; if (q_hit[0] !== 1'b1 || q_stage[2:0] !== 3'd1) begin errors++; $display("FAIL haz_stage1 got=%b/%0d exp=1/1", q_hit[0], q_stage[2:0]); end
        checks++; if (q_hit[1] !== 1'b0) begin errors++; $display("FAIL haz_miss got=%b exp=0", q_hit[1]); end
        fill_tags(5'd9, 5'd4, 5'd7, 5'd4, 5'd7, 5'b10001);
        q_tag = {5'd9, 5'd7};
        #1;
        checks++; if (q_hit[0] !== 1'b0) begin errors++; $display("FAIL haz_wen0 got=%b exp=0", q_hit[0]); end
        checks++; if (q_hit[1] !== 1'b1 || q_stage[5:3] !== 3'd4) begin errors++; $display("FAIL haz_oldest got=%b/%0d exp=1/4", q_hit[1], q_stage[5:3]); end
    endtask

    task automatic test_random();
        logic [N-1:0]  b;
        logic          h;
        logic [SW-1:0] st;
        logic          ok;
        do_reset();
        for (int t = 0; t < 400; t++) begin
            in_valid = ($urandom % 4) != 0;
            in_data  = {$urandom, $urandom, $urandom};
            in_tag   = TW'($urandom % 8);
            in_wen   = $urandom % 2;
            for (int s = 0; s < N; s++) stall_req[s] = ($urandom % 6) == 0;
            if ($urandom % 20 == 0) stall_req = '1;
            flush_req   = ($urandom % 10) == 0;
            flush_stage = SW'($urandom % 8);
            out_ready   = ($urandom % 4) != 0;
            q_tag       = {TW'($urandom % 8), TW'($urandom % 8)};
            #1;
            b = m_stuck();
            checks++; if (in_ready !== !b[0]) begin errors++; $display("FAIL rnd_in_ready t=%0d got=%b exp=%b", t, in_ready, !b[0]); end
            checks++; if (stage_valid !== m_valid_vec()) begin errors++; $display("FAIL rnd_valid t=%0d got=%b exp=%b", t, stage_valid, m_valid_vec()); end
            checks++; if (out_valid !== mv[N-1]) begin errors++; $display("FAIL rnd_out_valid t=%0d got=%b exp=%b", t, out_valid, mv[N-1]); end
            checks++; if (retire_cnt !== mcnt) begin errors++; $display("FAIL rnd_cnt t=%0d got=%0d exp=%0d", t, retire_cnt, mcnt); end
            for (int i = 0; i < NQ; i++) begin
                m_query(q_tag[i*TW +: TW], h, st);
                checks++;
                if (q_hit[i] !== h || q_stage[i*SW +: SW] !== st) begin
                    errors++; $display("FAIL rnd_query t=%0d q=%0d got=%b/%0d exp=%b/%0d", t, i, q_hit[i], q_stage[i*SW +: SW], h, st);
                end
            end
            for (int s = 0; s < N; s++) begin
                if (mv[s]) begin
                    checks++;
                    if (stage_data[s*DW +: DW] !== md[s]) begin
                        errors++; $display("FAIL rnd_data t=%0d s=%0d got=%h exp=%h", t, s, stage_data[s*DW +: DW], md[s]);
                    end
                end
            end
            tick();
        end
        ok = (got_q.size() == exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL rnd_retire_order got_n=%0d exp_n=%0d", got_q.size(), exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        force dut.retire_q = 32'hFFFF_FFF0;
        #1;
        release dut.retire_q;
        mcnt = 32'hFFFF_FFF0;
        for (int t = 0; t < 8; t++) begin
            in_valid = 1;
            in_data  = DW'(t + 1);
            tick();
        end
        checks++; if (retire_cnt !== 32'hFFFF_FFF3) begin errors++; $display("FAIL mid_cnt_pre got=%h exp=fffffff3", retire_cnt); end
        #2;
        rst = 1;
        #1;
        checks++; if (stage_valid !== 5'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%b/%b exp=00000/0", stage_valid, out_valid); end
        checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL mid_rst_cnt got=%h exp=0", retire_cnt); end
        #1;
        rst = 0;
        in_valid = 0;
        model_reset();
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_wrap();
        logic saw_max = 0, saw_zero = 0;
        do_reset();
        force dut.retire_q = 32'hFFFF_FFFE;
        #1;
        release dut.retire_q;
        mcnt = 32'hFFFF_FFFE;
        for (int t = 0; t < 12; t++) begin
            in_valid = (t < 3);
            in_data  = DW'(t + 1);
            tick();
            if (retire_cnt === 32'hFFFF_FFFF) saw_max = 1;
            if (retire_cnt === 32'd0) saw_zero = 1;
        end
        checks++; if (!(saw_max && saw_zero)) begin errors++; $display("FAIL wrap_seq got=%b%b exp=11", saw_max, saw_zero); end
        checks++; if (retire_cnt !== 32'd1) begin errors++; $display("FAIL wrap_final got=%h exp=1", retire_cnt); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_backpressure();
        test_flush();
        test_hazard();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
